// File: rtl/nonrestoring_divider.sv
// Sequential radix-2 non-restoring divider with a valid/ready handshake on
// both sides. One add or subtract on a (WIDTH+1)-bit partial remainder per
// clock, then a single fix-up cycle that restores a negative remainder.
// Optional macro DIVIDER_SIGNED_EN: two's complement operands, magnitudes
// divided and signs applied in the fix-up cycle (truncation toward zero).
module nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count;

    logic             accept;
    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign in_ready     = (state == IDLE);
    assign accept       = in_valid && in_ready;
    assign divisor_zero = (divisor == '0);

`ifdef DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic neg_q;
    logic neg_r;

    assign dividend_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
    assign q_final      = neg_q ? (~q_reg + ONE) : q_reg;
    assign r_final      = neg_r ? (~r_fix + ONE) : r_fix;

    // Remember the result signs at accept time so the fix-up cycle can apply them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign q_final      = q_reg;
    assign r_final      = r_fix;
`endif

    // One non-restoring step: shift {P,Q} left, then subtract D when P was
    // non-negative or add D when it was negative. Intermediate wrap in the
    // (WIDTH+1)-bit adder is harmless because the true result lies in [-D, D).
    assign p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign d_ext   = {1'b0, d_reg};
    assign p_step  = p_reg[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
    assign q_step  = {q_reg[WIDTH-2:0], ~p_step[WIDTH]};

    // Final restore: a negative P plus D is already in [0, D), so only the low bits matter.
    assign r_fix = p_reg[WIDTH-1:0] + (p_reg[WIDTH] ? d_reg : '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, iterate WIDTH times, fix up, hold until consumed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                next_state = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath and result registers; a reset discards any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_by_zero <= 1'b0;
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                        end else begin
                            p_reg <= '0;
                            q_reg <= dividend_mag;
                            d_reg <= divisor_mag;
                            count <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    p_reg <= p_step;
                    q_reg <= q_step;
                    count <= count - CW'(1);
                end
                FIX: begin
                    quotient  <= q_final;
                    remainder <= r_final;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider (WIDTH=8). A vector table plus
// hand-written sequences for backpressure and mid-division reset; expected
// results are queued on accept and compared when the result handshake fires.
// Define DIVIDER_SIGNED_EN for both files to exercise the signed build.
module tb_nonrestoring_divider;

    localparam int WIDTH = 8;
`ifdef DIVIDER_SIGNED_EN
    localparam int RAND_PAIRS = 3000;
`else
    localparam int RAND_PAIRS = 300;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               edges;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[$];

    always #5 clk = ~clk;

    nonrestoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Reference behaviour: plain integer division, with the zero-divisor convention.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            begin : signed_div
                int sa;
                int sb;
                sa  = int'($signed(a));
                sb  = int'($signed(b));
                e.q = WIDTH'(sa / sb);
                e.r = WIDTH'(sa % sb);
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive operands until accepted, queue the expected result, then scramble the pins.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input exp_t e);
        int waited;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_seen", 32'(in_ready), 32'd1);
        if (in_ready) begin
            exp_q.push_back(e);
        end
        step();
        in_valid = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    // Count edges after the accept edge until out_valid; finish the handshake if out_ready.
    task automatic waitResult(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            step();
            edges++;
        end
        checkOutput("out_valid_seen", 32'(out_valid), 32'd1);
        if (out_valid && out_ready) begin
            step();
        end
    endtask

    // Scoreboard: each completed result handshake pops and compares one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 32'(quotient), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("quotient", 32'(quotient), 32'(mon_e.q));
                checkOutput("remainder", 32'(remainder), 32'(mon_e.r));
                checkOutput("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
            end
        end
    end

    // Global time bound so the bench can never hang.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   edges;
        exp_t e;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // Edges after the accept edge until out_valid: WIDTH+1 normally, 0 for divide by zero.
        vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, WIDTH + 1});
        vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, WIDTH + 1});
        vecs.push_back('{8'd0,   8'd9,   8'd0,   8'd0,  1'b0, WIDTH + 1});
        vecs.push_back('{8'd5,   8'd200, 8'd0,   8'd5,  1'b0, WIDTH + 1});
        vecs.push_back('{8'd77,  8'd0,   8'hFF,  8'd77, 1'b1, 0});
        vecs.push_back('{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, WIDTH + 1});
`ifdef DIVIDER_SIGNED_EN
        vecs.push_back('{8'h9C,  8'd7,   8'hF2,  8'hFE, 1'b0, WIDTH + 1});
        vecs.push_back('{8'd100, 8'hF9,  8'hF2,  8'h02, 1'b0, WIDTH + 1});
        vecs.push_back('{8'h80,  8'hFF,  8'h80,  8'h00, 1'b0, WIDTH + 1});
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) step();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        #3 rst_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, '{vecs[i].q, vecs[i].r, vecs[i].dbz});
            waitResult(edges);
            checkOutput("latency", 32'(edges), 32'(vecs[i].edges));
        end

        // Backpressure: result must hold and new operands must be ignored.
        out_ready = 1'b0;
        e = model(8'd200, 8'd13);
        applyStimulus(8'd200, 8'd13, e);
        waitResult(edges);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            dividend = WIDTH'($urandom);
            divisor  = WIDTH'($urandom);
            step();
            checkOutput("bp_quotient", 32'(quotient), 32'(e.q));
            checkOutput("bp_remainder", 32'(remainder), 32'(e.r));
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset during the 4th RUN cycle discards the division.
        applyStimulus(8'd200, 8'd13, model(8'd200, 8'd13));
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_quotient", 32'(quotient), 32'd0);
        checkOutput("midrst_remainder", 32'(remainder), 32'd0);
        checkOutput("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        applyStimulus(8'd50, 8'd6, '{8'd8, 8'd2, 1'b0});
        waitResult(edges);
        checkOutput("post_reset_latency", 32'(edges), 32'(WIDTH + 1));

        // Random sweep against the reference model, with occasional zero divisors.
        for (int i = 0; i < RAND_PAIRS; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 16 == 0) ? '0 : WIDTH'($urandom);
            applyStimulus(ra, rb, model(ra, rb));
            waitResult(edges);
            checkOutput("rand_latency", 32'(edges), (rb == '0) ? 32'd0 : 32'(WIDTH + 1));
        end

        step();
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
